// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// fetch_sequencer
//   Instruction-fetch stage controller. Owns the program counter and the
//   IF/ID pipeline register and sequences them through start-up (IDLE),
//   normal fetch (RUN), hazard stalls (STALL) and branch redirects (FLUSH).
//   Redirect has priority over stall, which has priority over sequential fetch.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start            level; leaves IDLE when sampled high there
//   stall_i          load-use stall; holds PC and IF/ID
//   redirect_i       taken branch/jump from EX
//   redirect_pc_i    redirect target (low two bits forced to zero)
//   imem_inst_i      instruction read combinationally at imem_addr_o
//   imem_addr_o      current PC
//   ifid_inst_o      IF/ID instruction
//   ifid_pc_o        IF/ID PC
//   ifid_pc4_o       IF/ID PC+4
//   ifid_valid_o     IF/ID holds a live instruction
//   flush_o          combinational squash request to ID/EX
//   state_o          IDLE=00, RUN=01, STALL=10, FLUSH=11
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   perf_fetch_o     count of valid IF/ID loads (mod 2^32)
//   perf_bubble_o    count of non-IDLE cycles with no valid IF/ID load
module fetch_sequencer #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic [WIDTH-1:0] imem_inst_i,
  output logic [WIDTH-1:0] imem_addr_o,
  output logic [WIDTH-1:0] ifid_inst_o,
  output logic [WIDTH-1:0] ifid_pc_o,
  output logic [WIDTH-1:0] ifid_pc4_o,
  output logic             ifid_valid_o,
  output logic             flush_o,
  output logic [1:0]       state_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_o,
  output logic [31:0]      perf_bubble_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    FLUSH = 2'b11
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc4;
  logic             fetch;
  logic             take_redirect;

  // Modulo-2^WIDTH increment; wrap is silent.
  assign pc4 = pc + WIDTH'(4);

  always_comb begin
    state_n       = state;
    fetch         = 1'b0;
    take_redirect = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN, STALL: begin
        if (redirect_i) begin
          take_redirect = 1'b1;
          state_n       = FLUSH;
        end else if (stall_i) begin
          state_n = STALL;
        end else begin
          fetch   = 1'b1;
          state_n = RUN;
        end
      end
      FLUSH: begin
        // The stalling instruction was squashed, so stall_i is irrelevant here.
        if (redirect_i) begin
          take_redirect = 1'b1;
          state_n       = FLUSH;
        end else begin
          fetch   = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      ifid_inst_o  <= WIDTH'(32'h0000_0013);
      ifid_pc_o    <= '0;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
    end else begin
      state <= state_n;
      if (take_redirect) begin
        pc           <= {redirect_pc_i[WIDTH-1:2], 2'b00};
        ifid_valid_o <= 1'b0;
      end else if (fetch) begin
        pc           <= pc4;
        ifid_inst_o  <= imem_inst_i;
        ifid_pc_o    <= pc;
        ifid_pc4_o   <= pc4;
        ifid_valid_o <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_o  <= '0;
      perf_bubble_o <= '0;
    end else begin
      if (fetch) perf_fetch_o <= perf_fetch_o + 32'd1;
      if ((state != IDLE) && !fetch) perf_bubble_o <= perf_bubble_o + 32'd1;
    end
  end
`endif

  assign imem_addr_o = pc;
  assign flush_o     = take_redirect;
  assign state_o     = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// Directed bench for fetch_sequencer. Instruction memory is modelled as
// inst = ~addr, so every expected instruction is the complement of its PC.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_inst_i;
  logic [31:0] imem_addr_o;
  logic [31:0] ifid_inst_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
  logic        flush_o;
  logic [1:0]  state_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_bubble_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_inst_i = ~imem_addr_o;

  fetch_sequencer #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_inst_i   (imem_inst_i),
    .imem_addr_o   (imem_addr_o),
    .ifid_inst_o   (ifid_inst_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_valid_o  (ifid_valid_o),
    .flush_o       (flush_o),
    .state_o       (state_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_bubble_o (perf_bubble_o)
`endif
  );

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    #12;
    rst = 1'b0;
    step();
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr_o, 32'h0); end
    checks++; if (ifid_inst_o !== 32'h13) begin errors++; $display("FAIL reset_inst: got %h want %h", ifid_inst_o, 32'h13); end
    checks++; if ({ifid_pc_o, ifid_pc4_o} !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h/%h want 0/0", ifid_pc_o, ifid_pc4_o); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifid_valid_o); end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state_o); end
    // IDLE ignores redirect and stall, and never flushes.
    redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
    #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL idle_flush: got %b want 0", flush_o); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL idle_addr: got %h want %h", imem_addr_o, 32'h0); end
    checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL idle_state: got %b want 00", state_o); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", ifid_valid_o); end
    redirect_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL start_state: got %b want 01", state_o); end
    checks++; if ({imem_addr_o, ifid_valid_o} !== {32'h0, 1'b0}) begin errors++; $display("FAIL start_nofetch: addr %h valid %b want 0/0", imem_addr_o, ifid_valid_o); end
    start = 1'b0;
    step();
    checks++; if (ifid_pc_o !== 32'h0) begin errors++; $display("FAIL fetch0_pc: got %h want %h", ifid_pc_o, 32'h0); end
    checks++; if (ifid_inst_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL fetch0_inst: got %h want %h", ifid_inst_o, 32'hFFFF_FFFF); end
    checks++; if (ifid_pc4_o !== 32'h4) begin errors++; $display("FAIL fetch0_pc4: got %h want %h", ifid_pc4_o, 32'h4); end
    checks++; if (ifid_valid_o !== 1'b1) begin errors++; $display("FAIL fetch0_valid: got %b want 1", ifid_valid_o); end
    checks++; if (imem_addr_o !== 32'h4) begin errors++; $display("FAIL fetch0_addr: got %h want %h", imem_addr_o, 32'h4); end
    step();
    checks++; if (ifid_pc_o !== 32'h4) begin errors++; $display("FAIL fetch1_pc: got %h want %h", ifid_pc_o, 32'h4); end
    step();
    checks++; if (ifid_pc_o !== 32'h8) begin errors++; $display("FAIL fetch2_pc: got %h want %h", ifid_pc_o, 32'h8); end
    checks++; if (ifid_inst_o !== 32'hFFFF_FFF7) begin errors++; $display("FAIL fetch2_inst: got %h want %h", ifid_inst_o, 32'hFFFF_FFF7); end
    step();
    checks++; if ({ifid_pc_o, imem_addr_o} !== {32'hC, 32'h10}) begin errors++; $display("FAIL fetch3: pc %h addr %h want c/10", ifid_pc_o, imem_addr_o); end
    checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL start_hold: got %b want 01", state_o); end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    step();
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL stall1_state: got %b want 10", state_o); end
    checks++; if ({imem_addr_o, ifid_pc_o, ifid_valid_o} !== {32'h10, 32'hC, 1'b1}) begin errors++; $display("FAIL stall1_hold: addr %h pc %h valid %b want 10/c/1", imem_addr_o, ifid_pc_o, ifid_valid_o); end
    step();
    checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL stall2_state: got %b want 10", state_o); end
    checks++; if ({imem_addr_o, ifid_pc_o} !== {32'h10, 32'hC}) begin errors++; $display("FAIL stall2_hold: addr %h pc %h want 10/c", imem_addr_o, ifid_pc_o); end
    stall_i = 1'b0;
    step();
    checks++; if (ifid_pc_o !== 32'h10) begin errors++; $display("FAIL unstall_pc: got %h want %h", ifid_pc_o, 32'h10); end
    checks++; if ({imem_addr_o, state_o} !== {32'h14, 2'b01}) begin errors++; $display("FAIL unstall_addr: addr %h state %b want 14/01", imem_addr_o, state_o); end
    for (int i = 0; i < 3; i++) step();
    checks++; if ({imem_addr_o, ifid_pc_o} !== {32'h20, 32'h1C}) begin errors++; $display("FAIL post_stall: addr %h pc %h want 20/1c", imem_addr_o, ifid_pc_o); end
  endtask

  task automatic test_redirect();
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL redir_flush: got %b want 1", flush_o); end
    step();
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want %h", imem_addr_o, 32'h100); end
    checks++; if (ifid_valid_o !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b want 0", ifid_valid_o); end
    checks++; if (state_o !== 2'b11) begin errors++; $display("FAIL redir_state: got %b want 11", state_o); end
    redirect_i = 1'b0;
    #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL redir_flush_drop: got %b want 0", flush_o); end
    step();
    checks++; if ({ifid_pc_o, ifid_valid_o} !== {32'h100, 1'b1}) begin errors++; $display("FAIL redir_target: pc %h valid %b want 100/1", ifid_pc_o, ifid_valid_o); end
    checks++; if (ifid_inst_o !== 32'hFFFF_FEFF) begin errors++; $display("FAIL redir_inst: got %h want %h", ifid_inst_o, 32'hFFFF_FEFF); end
    checks++; if ({imem_addr_o, state_o} !== {32'h104, 2'b01}) begin errors++; $display("FAIL redir_resume: addr %h state %b want 104/01", imem_addr_o, state_o); end
  endtask

  task automatic test_perf();
`ifdef FETCH_PERF_CNT_EN
    // Fetches 0..1c (8) + 100 + 104 = 10; bubbles: 2 stall + 1 redirect = 3.
    step();
    checks++; if (perf_fetch_o !== 32'd10) begin errors++; $display("FAIL perf_fetch: got %0d want 10", perf_fetch_o); end
    checks++; if (perf_bubble_o !== 32'd3) begin errors++; $display("FAIL perf_bubble: got %0d want 3", perf_bubble_o); end
`endif
  endtask

  task automatic test_redirect_stall();
    redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h200;
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rs_flush: got %b want 1", flush_o); end
    step();
    checks++; if ({state_o, imem_addr_o, ifid_valid_o} !== {2'b11, 32'h200, 1'b0}) begin errors++; $display("FAIL rs_win: state %b addr %h valid %b want 11/200/0", state_o, imem_addr_o, ifid_valid_o); end
    // A second redirect while in FLUSH reloads the PC and stays in FLUSH.
    redirect_pc_i = 32'h302;
    #1;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rs_flush2: got %b want 1", flush_o); end
    step();
    checks++; if ({state_o, imem_addr_o, ifid_valid_o} !== {2'b11, 32'h300, 1'b0}) begin errors++; $display("FAIL rs_reflush: state %b addr %h valid %b want 11/300/0", state_o, imem_addr_o, ifid_valid_o); end
    redirect_i = 1'b0;
    step();
    checks++; if ({ifid_pc_o, ifid_valid_o, state_o} !== {32'h300, 1'b1, 2'b01}) begin errors++; $display("FAIL rs_target: pc %h valid %b state %b want 300/1/01", ifid_pc_o, ifid_valid_o, state_o); end
    stall_i = 1'b0;
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    step();
    checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want %h", imem_addr_o, 32'hFFFF_FFFC); end
    redirect_i = 1'b0;
    step();
    checks++; if ({ifid_pc_o, ifid_pc4_o} !== {32'hFFFF_FFFC, 32'h0}) begin errors++; $display("FAIL wrap_ifid: pc %h pc4 %h want fffffffc/0", ifid_pc_o, ifid_pc4_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h want %h", imem_addr_o, 32'h0); end
    step();
    checks++; if ({ifid_pc_o, ifid_pc4_o, ifid_inst_o} !== {32'h0, 32'h4, 32'hFFFF_FFFF}) begin errors++; $display("FAIL wrap_next: pc %h pc4 %h inst %h want 0/4/ffffffff", ifid_pc_o, ifid_pc4_o, ifid_inst_o); end
  endtask

  task automatic test_reset_mid();
    step();
    redirect_i = 1'b1; redirect_pc_i = 32'h500;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({imem_addr_o, ifid_valid_o, state_o} !== {32'h0, 1'b0, 2'b00}) begin errors++; $display("FAIL arst_state: addr %h valid %b state %b want 0/0/00", imem_addr_o, ifid_valid_o, state_o); end
    checks++; if ({ifid_inst_o, ifid_pc_o, ifid_pc4_o} !== {32'h13, 32'h0, 32'h0}) begin errors++; $display("FAIL arst_ifid: inst %h pc %h pc4 %h want 13/0/0", ifid_inst_o, ifid_pc_o, ifid_pc4_o); end
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL arst_flush: got %b want 0", flush_o); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if ({perf_fetch_o, perf_bubble_o} !== 64'h0) begin errors++; $display("FAIL arst_perf: fetch %0d bubble %0d want 0/0", perf_fetch_o, perf_bubble_o); end
`endif
    rst = 1'b0; redirect_i = 1'b0;
    step();
    checks++; if ({state_o, imem_addr_o} !== {2'b00, 32'h0}) begin errors++; $display("FAIL arst_idle: state %b addr %h want 00/0", state_o, imem_addr_o); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stall();
    test_redirect();
    test_perf();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block for the pipeline's instruction-fetch stage. It owns the program counter and the IF/ID pipeline register, and sequences them through start-up, normal fetch, hazard stalls and branch redirects. It drives the instruction memory address and takes back its combinational instruction. It also replaces the ad-hoc `branch & zero` PC select with prioritised redirect/stall handling from the hazard unit and the EX stage.

## Interface
Parameters:
- WIDTH, 32, PC and instruction width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  level; begins fetching when sampled high in IDLE
- stall_i  input  1  load-use stall from hazard unit; hold PC and IF/ID
- redirect_i  input  1  taken branch/jump resolved in EX
- redirect_pc_i  input  WIDTH  redirect target
- imem_inst_i  input  WIDTH  instruction read combinationally at imem_addr_o
- imem_addr_o  output  WIDTH  current PC (registered)
- ifid_inst_o  output  WIDTH  IF/ID instruction
- ifid_pc_o  output  WIDTH  IF/ID PC
- ifid_pc4_o  output  WIDTH  IF/ID PC+4
- ifid_valid_o  output  1  IF/ID holds a live instruction
- flush_o  output  1  combinational; tells ID/EX to squash its instruction this cycle
- state_o  output  2  FSM state: IDLE=00, RUN=01, STALL=10, FLUSH=11

## Operation
- **Reset values:**
  - pc = RESET_PC
  - ifid_inst_o = 32'h0000_0013 (NOP)
  - ifid_pc_o = 0, ifid_pc4_o = 0, ifid_valid_o = 0
  - state = IDLE
  - flush_o = 0
- **Priority** in RUN and STALL: redirect_i > stall_i > sequential fetch.
- **IDLE:**
  - PC and IF/ID are held, ifid_valid_o = 0.
  - redirect_i and stall_i are ignored, and flush_o = 0.
  - start=1 moves the FSM to RUN. No fetch is performed in the transition cycle.
- **RUN, redirect_i=1:**
  - pc <= {redirect_pc_i[WIDTH-1:2], 2'b00}; low bits are always forced to zero.
  - ifid_valid_o <= 0, flush_o = 1, next state FLUSH.
- **RUN, stall_i=1:** PC and all IF/ID fields hold, next state STALL.
- **RUN, otherwise:**
  - ifid_inst_o <= imem_inst_i, ifid_pc_o <= pc, ifid_pc4_o <= pc+4, ifid_valid_o <= 1.
  - pc <= pc+4.
- **STALL:** same rules as RUN. When stall_i drops, the fetch happens in that same cycle and the next state is RUN.
- **FLUSH:**
  - stall_i is ignored, since the stalling instruction was squashed.
  - A normal fetch at the target PC is performed and the next state is RUN.
  - A new redirect_i takes precedence: it reloads pc, keeps ifid_valid_o = 0, asserts flush_o and stays in FLUSH.
- **Arithmetic:** pc+4 is WIDTH-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- **Reset mid-operation:** all state returns immediately to reset values, independent of clk.
- start is sampled only in IDLE. Deasserting it later has no effect.

## Timing
- imem_addr_o equals the PC register, and the instruction memory read is combinational within the cycle.
- Fetch latency: the instruction at PC p is presented at edge N and appears on ifid_inst_o, with ifid_valid_o = 1, after edge N.
- Redirect penalty: redirect_i sampled at edge N gives:
  - pc = target and ifid_valid_o = 0 after edge N;
  - the target instruction valid in IF/ID after edge N+1.
- flush_o = redirect_i & (state != IDLE). It is purely combinational and is registered by the consumer.
- A stall adds exactly one held cycle per cycle of stall_i = 1; no instruction is lost or duplicated.

## Configuration
- **FETCH_PERF_CNT_EN defined:** adds two outputs, both cleared by rst and wrapping modulo 2^32.
  - perf_fetch_o (32): increments on every IF/ID load with valid = 1.
  - perf_bubble_o (32): increments on every non-IDLE cycle where IF/ID is not loaded with a valid instruction (stall or flush).
- **Undefined:** these ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- **Reset then start:**
  - rst pulse, start=0 for 3 cycles → imem_addr_o = 0, ifid_valid_o = 0, state_o = 00.
  - start=1 → RUN; after the next edges, ifid_pc_o = 0, 4, 8 with valid = 1.
- **Stall:** stall_i=1 for 2 cycles at pc = 0x10 → pc and IF/ID held for 2 cycles, state_o = 10. The next edge loads pc 0x10 with no duplicate or skip.
- **Redirect:** redirect_i=1, redirect_pc_i=0x103 at pc = 0x20 → flush_o = 1 that cycle; pc = 0x100 and valid = 0 after the edge; ifid_pc_o = 0x100 one edge later.
- **Simultaneous redirect and stall:** redirect_i=1 and stall_i=1 in RUN → redirect wins and state = FLUSH. Holding stall_i=1 during FLUSH still fetches the target.
- **Wrap-around:** redirect to 0xFFFF_FFFC → ifid_pc4_o = 0 and the next pc = 0.
- **FETCH_PERF_CNT_EN:** a run of 10 fetches, 2 stall cycles and 1 redirect gives perf_fetch_o = 10 and perf_bubble_o = 3. Asserting rst mid-run clears all counters and outputs asynchronously.
